// File: rtl/ssc_tx.sv
// ssc_tx: spread-spectrum transmit channel. A DDS carrier drives a quarter-wave sine
// table, a Galois-LFSR PRN chip spreads its sign, and each accepted tick yields a DAC sample.
module ssc_tx #(
  parameter logic [15:0] BASE    = 16'h0900,
  parameter bit          SAT_NEG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] Wdata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] Rdata,
  input  logic        tick,
  output logic [15:0] DAC,
  output logic        pushDAC,
  output logic        epoch
);

  localparam logic [15:0] A_GRUN   = 16'h0100;
  localparam logic [15:0] A_CTRL   = BASE + 16'h0000;
  localparam logic [15:0] A_CFREQ  = BASE + 16'h0004;
  localparam logic [15:0] A_CPHASE = BASE + 16'h0008;
  localparam logic [15:0] A_HFREQ  = BASE + 16'h000C;
  localparam logic [15:0] A_HPHASE = BASE + 16'h0010;
  localparam logic [15:0] A_PRN    = BASE + 16'h0014;
  localparam logic [15:0] A_SCNT   = BASE + 16'h0018;
  localparam logic [15:0] A_ECNT   = BASE + 16'h001C;
  localparam logic [15:0] A_STATUS = BASE + 16'h0020;

  typedef struct packed {
    logic [3:0]  hob;
    logic [13:0] poly;
    logic [13:0] state;
  } prn_t;

  // Quarter-wave table: parabolic fit a*(16384-a)/2048, 0 at a=0 rising to 16'h7FFF at 13'h1FFF.
  function automatic logic [15:0] sine_mag(input logic [12:0] a);
    logic [27:0] p;
    p = {15'd0, a} * (28'd16384 - {15'd0, a});
    return p[26:11];
  endfunction

  // hob may point past bit 13; such positions read as 0.
  function automatic logic bit_at(input logic [13:0] v, input logic [3:0] i);
    logic [15:0] ext;
    ext = {2'b00, v};
    return ext[i];
  endfunction

  logic [15:0] addr16;
  logic        unused_addr_hi;

  assign addr16         = addr[15:0];
  assign unused_addr_hi = ^addr[31:16];

  // Register file
  logic [31:0] grun_q, grun_d;
  logic        ctrl_q, ctrl_d;
  logic [31:0] car_freq_q, car_freq_d;
  logic [31:0] car_phase_q, car_phase_d;
  logic [31:0] chip_freq_q, chip_freq_d;
  logic [31:0] chip_phase_q, chip_phase_d;
  prn_t        prn_q, prn_d;
  logic [31:0] sample_count_q, sample_count_d;
  logic [31:0] epoch_count_q, epoch_count_d;
  logic        epoch_seen_q, epoch_seen_d;

  // Sample pipeline
  logic        s1_valid_q, s1_valid_d;
  logic [1:0]  s1_quad_q, s1_quad_d;
  logic        s1_chip_q, s1_chip_d;
  logic [15:0] sv_q, sv_d;
  logic [15:0] dac_q, dac_d;
  logic        push_q, push_d;
  logic        epoch_q, epoch_d;

  logic        run;
  logic        accept;
  logic        advance;
  logic        chip_now;
  logic        neg;
  logic        rd_status;
  logic [31:0] car_phase_nx;
  logic [31:0] chip_phase_nx;
  logic [12:0] rom_addr;
  logic [13:0] lfsr_clr;
  logic [13:0] lfsr_nx;
  logic [15:0] neg_val;

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    grun_d         = grun_q;
    ctrl_d         = ctrl_q;
    car_freq_d     = car_freq_q;
    car_phase_d    = car_phase_q;
    chip_freq_d    = chip_freq_q;
    chip_phase_d   = chip_phase_q;
    prn_d          = prn_q;
    sample_count_d = sample_count_q;
    epoch_count_d  = epoch_count_q;
    epoch_seen_d   = epoch_seen_q;

    run           = (grun_q != 32'd0) && ctrl_q;
    accept        = tick && run;
    car_phase_nx  = car_phase_q + car_freq_q;
    chip_phase_nx = chip_phase_q + chip_freq_q;
    advance       = accept && chip_phase_nx[31] && !chip_phase_q[31];

    chip_now = bit_at(prn_q.state, prn_q.hob);
    lfsr_clr = prn_q.state & ~(14'd1 << prn_q.hob);
    lfsr_nx  = {lfsr_clr[12:0], 1'b0} ^ (chip_now ? prn_q.poly : 14'd0);

    // Stage 0: odd quadrants walk the quarter table backwards.
    rom_addr   = car_phase_q[30] ? ~car_phase_q[29:17] : car_phase_q[29:17];
    s1_valid_d = accept;
    s1_quad_d  = car_phase_q[31:30];
    s1_chip_d  = chip_now;
    sv_d       = sine_mag(rom_addr);

    if (accept) begin
      car_phase_d    = car_phase_nx;
      chip_phase_d   = chip_phase_nx;
      sample_count_d = sample_count_q + 32'd1;
      if (advance) prn_d.state = lfsr_nx;
    end
    epoch_d = advance && (lfsr_nx == 14'h0001);

    // Stage 2: quadrant sign and chip sign fold into a single negation.
    neg     = s1_quad_q[1] ^ s1_chip_q;
    neg_val = 16'd0 - sv_q;
    if (SAT_NEG && (sv_q == 16'h8000)) neg_val = 16'h7FFF;
    push_d = s1_valid_q;
    dac_d  = dac_q;
    if (s1_valid_q) dac_d = neg ? neg_val : sv_q;

    // A set in the same cycle as a clearing STATUS read takes priority.
    rd_status = read && (addr16 == A_STATUS);
    if (rd_status) epoch_seen_d = 1'b0;
    if (epoch_q) begin
      epoch_seen_d  = 1'b1;
      epoch_count_d = epoch_count_q + 32'd1;
    end

    // Bus writes come last so they override same-cycle tick updates.
    if (write) begin
      case (addr16)
        A_GRUN:   grun_d         = Wdata;
        A_CTRL:   ctrl_d         = Wdata[0];
        A_CFREQ:  car_freq_d     = Wdata;
        A_CPHASE: car_phase_d    = Wdata;
        A_HFREQ:  chip_freq_d    = Wdata;
        A_HPHASE: chip_phase_d   = Wdata;
        A_PRN:    prn_d          = Wdata;
        A_SCNT:   sample_count_d = Wdata;
        A_ECNT:   epoch_count_d  = Wdata;
        default:  ;
      endcase
    end
  end

  always_comb begin
    Rdata = 32'd0;
    if (read) begin
      case (addr16)
        A_CTRL:   Rdata = {31'd0, ctrl_q};
        A_CFREQ:  Rdata = car_freq_q;
        A_CPHASE: Rdata = car_phase_q;
        A_HFREQ:  Rdata = chip_freq_q;
        A_HPHASE: Rdata = chip_phase_q;
        A_PRN:    Rdata = prn_q;
        A_SCNT:   Rdata = sample_count_q;
        A_ECNT:   Rdata = epoch_count_q;
        A_STATUS: Rdata = {31'd0, epoch_seen_q};
        default:  Rdata = 32'd0;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      grun_q         <= '0;
      ctrl_q         <= 1'b0;
      car_freq_q     <= '0;
      car_phase_q    <= '0;
      chip_freq_q    <= '0;
      chip_phase_q   <= '0;
      prn_q          <= '0;
      sample_count_q <= '0;
      epoch_count_q  <= '0;
      epoch_seen_q   <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_quad_q      <= '0;
      s1_chip_q      <= 1'b0;
      sv_q           <= '0;
      dac_q          <= '0;
      push_q         <= 1'b0;
      epoch_q        <= 1'b0;
    end else begin
      grun_q         <= grun_d;
      ctrl_q         <= ctrl_d;
      car_freq_q     <= car_freq_d;
      car_phase_q    <= car_phase_d;
      chip_freq_q    <= chip_freq_d;
      chip_phase_q   <= chip_phase_d;
      prn_q          <= prn_d;
      sample_count_q <= sample_count_d;
      epoch_count_q  <= epoch_count_d;
      epoch_seen_q   <= epoch_seen_d;
      s1_valid_q     <= s1_valid_d;
      s1_quad_q      <= s1_quad_d;
      s1_chip_q      <= s1_chip_d;
      sv_q           <= sv_d;
      dac_q          <= dac_d;
      push_q         <= push_d;
      epoch_q        <= epoch_d;
    end
  end

  assign DAC     = dac_q;
  assign pushDAC = push_q;
  assign epoch   = epoch_q;

endmodule

// File: tb/tb_ssc_tx.sv
// tb_ssc_tx: scoreboard bench for ssc_tx; a phase-accumulator/LFSR reference model
// queues expected samples and epoch times, a negedge monitor checks them.
module tb_ssc_tx;
  localparam logic [15:0] BASE     = 16'h0900;
  localparam logic [15:0] A_GRUN   = 16'h0100;
  localparam logic [15:0] A_CTRL   = BASE + 16'h0000;
  localparam logic [15:0] A_CFREQ  = BASE + 16'h0004;
  localparam logic [15:0] A_CPHASE = BASE + 16'h0008;
  localparam logic [15:0] A_HFREQ  = BASE + 16'h000C;
  localparam logic [15:0] A_HPHASE = BASE + 16'h0010;
  localparam logic [15:0] A_PRN    = BASE + 16'h0014;
  localparam logic [15:0] A_SCNT   = BASE + 16'h0018;
  localparam logic [15:0] A_ECNT   = BASE + 16'h001C;
  localparam logic [15:0] A_STATUS = BASE + 16'h0020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] rdata;
  logic        tick = 1'b0;
  logic [15:0] dac;
  logic        push_dac;
  logic        epoch;

  ssc_tx #(.BASE(BASE), .SAT_NEG(1'b1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .Wdata(wdata), .write(write), .read(read),
    .Rdata(rdata), .tick(tick), .DAC(dac), .pushDAC(push_dac), .epoch(epoch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [15:0] val; int due; } exp_t;
  exp_t exp_q[$];
  int   ep_q[$];

  // Reference model state
  logic [31:0] m_grun, m_car_freq, m_car_phase, m_chip_freq, m_chip_phase;
  logic [31:0] m_samples, m_epochs;
  logic        m_ctrl;
  logic [3:0]  m_hob;
  logic [13:0] m_poly, m_state;
  bit          m_force = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_t mon_e;
  int   mon_d;
  always @(negedge clk) begin
    if (!rst) begin
      if (push_dac) begin
        if (exp_q.size() == 0) check("unexpected_push", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("dac_value", {16'd0, dac}, {16'd0, mon_e.val});
          check("push_latency", cyc, mon_e.due);
        end
      end
      if (epoch) begin
        if (ep_q.size() == 0) check("unexpected_epoch", 32'd1, 32'd0);
        else begin
          mon_d = ep_q.pop_front();
          check("epoch_time", cyc, mon_d);
        end
      end
    end
  end

  // Ideal quarter-sine magnitude: 32768 * x*(2-x) with x = idx/8192, floored.
  function automatic int sine_ref(input int idx);
    return (idx * (16384 - idx)) / 2048;
  endfunction

  task automatic model_reset();
    m_grun = 0; m_car_freq = 0; m_car_phase = 0; m_chip_freq = 0; m_chip_phase = 0;
    m_samples = 0; m_epochs = 0; m_ctrl = 0; m_hob = 0; m_poly = 0; m_state = 0;
    exp_q.delete();
    ep_q.delete();
  endtask

  task automatic model_tick();
    int quad, pos, idx, mag, v, s;
    bit chip, neg;
    logic [31:0] nphase;
    exp_t e;
    if (m_grun != 0 && m_ctrl) begin
      quad = int'(m_car_phase[31:30]);
      pos  = int'(m_car_phase[29:17]);
      idx  = (quad % 2 == 1) ? 8191 - pos : pos;
      mag  = m_force ? 32768 : sine_ref(idx);
      chip = ((int'(m_state) >> m_hob) & 1) == 1;
      neg  = (quad >= 2) ^ chip;
      v    = neg ? -mag : mag;
      if (v < -32767) v = 32767;
      e.val = 16'(v);
      e.due = cyc + 2;
      exp_q.push_back(e);
      nphase = m_chip_phase + m_chip_freq;
      if (nphase[31] && !m_chip_phase[31]) begin
        s = int'(m_state);
        s = s & ~(1 << m_hob);
        s = (s << 1) & 32'h3FFF;
        if (chip) s = s ^ int'(m_poly);
        m_state = 14'(s);
        if (s == 1) begin
          ep_q.push_back(cyc + 1);
          m_epochs = m_epochs + 1;
        end
      end
      m_car_phase  = m_car_phase + m_car_freq;
      m_chip_phase = nphase;
      m_samples    = m_samples + 1;
    end
  endtask

  task automatic model_write(input logic [15:0] a, input logic [31:0] d);
    case (a)
      A_GRUN:   m_grun = d;
      A_CTRL:   m_ctrl = d[0];
      A_CFREQ:  m_car_freq = d;
      A_CPHASE: m_car_phase = d;
      A_HFREQ:  m_chip_freq = d;
      A_HPHASE: m_chip_phase = d;
      A_PRN:    {m_hob, m_poly, m_state} = d;
      A_SCNT:   m_samples = d;
      A_ECNT:   m_epochs = d;
      default:  ;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    addr  = {16'($urandom), a};
    wdata = d;
    write = 1'b1;
    model_write(a, d);
    cycle();
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    addr = {16'($urandom), a};
    read = 1'b1;
    #2;
    d = rdata;
    cycle();
    read = 1'b0;
  endtask

  task automatic tick_cycle();
    tick = 1'b1;
    model_tick();
    cycle();
    tick = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && (exp_q.size() != 0 || ep_q.size() != 0); i++) cycle();
    check(name, exp_q.size() + ep_q.size(), 32'd0);
  endtask

  logic [31:0] rd;
  logic [15:0] all_regs [11] = '{A_GRUN, A_CTRL, A_CFREQ, A_CPHASE, A_HFREQ, A_HPHASE,
                                 A_PRN, A_SCNT, A_ECNT, A_STATUS, BASE + 16'h0024};
  logic [13:0] seq [8] = '{14'd1, 14'd2, 14'd4, 14'd8, 14'd3, 14'd6, 14'd12, 14'd11};

  initial begin
    model_reset();
    // 1. Reset state
    rst = 1'b1;
    repeat (2) begin
      cycle();
      check("rst_dac", {16'd0, dac}, 32'd0);
      check("rst_push", {31'd0, push_dac}, 32'd0);
    end
    rst = 1'b0;
    cycle();
    check("post_rst_push", {31'd0, push_dac}, 32'd0);
    check("post_rst_dac", {16'd0, dac}, 32'd0);
    foreach (all_regs[i]) begin
      bus_read(all_regs[i], rd);
      check($sformatf("reset_read_%h", all_regs[i]), rd, 32'd0);
    end

    // 2. Quadrant sweep, back-to-back ticks
    bus_write(A_GRUN, 32'd1);
    bus_write(A_CTRL, 32'd1);
    bus_write(A_CFREQ, 32'h4000_0000);
    bus_write(A_HFREQ, 32'd0);
    bus_write(A_PRN, 32'd0);
    repeat (4) tick_cycle();
    wait_drain("drain_quadrant");
    addr = {16'd0, A_CFREQ};
    #1;
    check("rdata_read_low", rdata, 32'd0);

    // 3. LFSR period and epoch spacing
    bus_write(A_CFREQ, 32'd0);
    bus_write(A_CPHASE, 32'd0);
    bus_write(A_PRN, {4'd3, 14'd3, 14'd1});
    bus_write(A_HPHASE, 32'd0);
    bus_write(A_HFREQ, 32'h8000_0000);
    bus_write(A_ECNT, 32'd0);
    bus_read(A_STATUS, rd);
    for (int i = 0; i < 8; i++) begin
      bus_read(A_PRN, rd);
      check($sformatf("lfsr_state_%0d", i), {18'd0, rd[13:0]}, {18'd0, seq[i]});
      repeat (2) tick_cycle();
    end
    repeat (44) tick_cycle();
    wait_drain("drain_lfsr");
    bus_read(A_ECNT, rd);
    check("epoch_count_60", rd, 32'd2);
    bus_read(A_STATUS, rd);
    check("status_set", rd, 32'd1);
    bus_read(A_STATUS, rd);
    check("status_cleared", rd, 32'd0);

    // 4. Chip spreading: quad 00 negated, quad 10 not double-negated
    bus_write(A_HFREQ, 32'd0);
    bus_write(A_PRN, {4'd0, 14'd0, 14'd1});
    bus_write(A_CPHASE, 32'h1000_0000);
    tick_cycle();
    bus_write(A_CPHASE, 32'h9000_0000);
    tick_cycle();
    wait_drain("drain_spread");

    // 5a. Write and tick colliding on CAR_PHASE
    bus_write(A_CFREQ, 32'h0100_0000);
    tick = 1'b1;
    write = 1'b1;
    addr = {16'd0, A_CPHASE};
    wdata = 32'h1234_5678;
    model_tick();
    model_write(A_CPHASE, 32'h1234_5678);
    cycle();
    tick = 1'b0;
    write = 1'b0;
    bus_read(A_CPHASE, rd);
    check("collide_car_phase", rd, 32'h1234_5678);
    wait_drain("drain_collide");

    // 5b. STATUS read in the epoch cycle
    bus_write(A_PRN, {4'd3, 14'd3, 14'd9});
    bus_write(A_HPHASE, 32'd0);
    bus_write(A_HFREQ, 32'h8000_0000);
    bus_read(A_STATUS, rd);
    tick_cycle();
    check("epoch_cycle_pulse", {31'd0, epoch}, 32'd1);
    bus_read(A_STATUS, rd);
    bus_read(A_STATUS, rd);
    check("status_set_wins", rd, 32'd1);
    wait_drain("drain_status");

    // 5c. Negating a forced 16'h8000 magnitude saturates
    bus_write(A_HFREQ, 32'd0);
    bus_write(A_PRN, 32'd0);
    bus_write(A_CFREQ, 32'd0);
    bus_write(A_CPHASE, 32'h8000_0000);
    force dut.sv_q = 16'h8000;
    m_force = 1'b1;
    tick_cycle();
    m_force = 1'b0;
    wait_drain("drain_sat");
    release dut.sv_q;

    // Disabling mid-stream: in-flight samples finish, later ticks are ignored
    bus_write(A_CFREQ, 32'h0765_4321);
    repeat (2) tick_cycle();
    tick = 1'b1;
    write = 1'b1;
    addr = {16'd0, A_CTRL};
    wdata = 32'd0;
    model_tick();
    model_write(A_CTRL, 32'd0);
    cycle();
    write = 1'b0;
    wait_drain("drain_disable");
    repeat (4) begin
      tick_cycle();
      #3;
      check("disabled_no_push", {31'd0, push_dac}, 32'd0);
    end

    // 6. Reset one cycle after a tick
    bus_write(A_CTRL, 32'd1);
    tick_cycle();
    rst = 1'b1;
    model_reset();
    cycle();
    rst = 1'b0;
    repeat (4) begin
      cycle();
      check("rst_midstream_no_push", {31'd0, push_dac}, 32'd0);
    end
    bus_read(A_SCNT, rd);
    check("rst_sample_count", rd, 32'd0);
    bus_write(A_GRUN, 32'd1);
    bus_write(A_CTRL, 32'd1);
    tick_cycle();
    wait_drain("drain_after_rst");

    // Randomized configurations with random tick gaps
    for (int blk = 0; blk < 8; blk++) begin
      bus_write(A_GRUN, $urandom_range(32'hFFFF, 1));
      bus_write(A_CFREQ, $urandom);
      bus_write(A_CPHASE, $urandom);
      bus_write(A_HFREQ, (blk % 2 == 0) ? 32'h8000_0000 : $urandom);
      bus_write(A_HPHASE, $urandom);
      bus_write(A_PRN, {4'($urandom_range(15, 0)), 14'($urandom), 14'($urandom_range(16383, 1))});
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(1, 0) == 1) tick_cycle();
        else cycle();
      end
      wait_drain("drain_random");
      bus_read(A_SCNT, rd);
      check("rand_sample_count", rd, m_samples);
      bus_read(A_ECNT, rd);
      check("rand_epoch_count", rd, m_epochs);
      bus_read(A_CPHASE, rd);
      check("rand_car_phase", rd, m_car_phase);
      bus_read(A_PRN, rd);
      check("rand_prn", rd, {m_hob, m_poly, m_state});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
